operand_fetch: RTL

Operand-fetch stage between instruction decode and execute. It drives the two read addresses of the register file and captures that file's one-cycle-registered read data. It snoops the register-file write port so operands are never stale, whether a write lands on the same edge as a read or while an instruction is waiting. Decoded fields and the resolved 32-bit operands go to execute under a valid/ready handshake, at one instruction per cycle.

---
 rtl/operand_fetch_if.sv | 57 +++++
 rtl/operand_fetch.sv | 138 +++++++++++++
 2 files changed

// File: rtl/operand_fetch_if.sv
// operand_fetch_if
//   Bundles every non-clock, non-reset signal of the operand-fetch stage.
//   Signal groups:
//     in_*   decode -> fetch instruction handshake and decoded fields
//     rf_*   fetch <-> register file read ports (data is one-cycle registered)
//     wb_*   register-file write port, snooped for forwarding
//     out_*  fetch -> execute handshake, payload and resolved operands
//   Modports:
//     slave  : the operand_fetch stage itself
//     master : the environment (decode, register file, execute)

interface operand_fetch_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;

    logic [4:0]  rf_addra;
    logic [4:0]  rf_addrb;
    logic [31:0] rf_dataa;
    logic [31:0] rf_datab;

    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_op;
    logic [4:0]  out_rd;
    logic [15:0] out_imm;
    logic [31:0] out_a;
    logic [31:0] out_b;

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        output in_ready,
        output rf_addra, rf_addrb,
        input  rf_dataa, rf_datab,
        input  wb_en, wb_addr, wb_data,
        output out_valid, out_op, out_rd, out_imm, out_a, out_b,
        input  out_ready
    );

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        input  in_ready,
        input  rf_addra, rf_addrb,
        output rf_dataa, rf_datab,
        output wb_en, wb_addr, wb_data,
        input  out_valid, out_op, out_rd, out_imm, out_a, out_b,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch
//   Two-stage operand fetch between decode and execute.
//   P stage: instruction whose register-file read addresses have been issued.
//   O stage: output register holding the payload and resolved operands.
//   The register-file write port is snooped so that operands never go stale,
//   both for writes that coincide with a read edge and for writes that land
//   while an instruction waits in P or O.
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous, active-low; clears all pipeline state
//     bus    operand_fetch_if.slave (decode, register-file and execute sides)

module operand_fetch (
    input  logic           clock,
    input  logic           reset,
    operand_fetch_if.slave bus
);

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic        fwd_a;
        logic        fwd_b;
        logic [31:0] fwd_data_a;
        logic [31:0] fwd_data_b;
    } p_entry_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] a;
        logic [31:0] b;
    } o_entry_t;

    logic     p_valid_q, p_valid_d;
    logic     o_valid_q, o_valid_d;
    p_entry_t p_q, p_d;
    o_entry_t o_q, o_d;

    logic       adv_o, adv_p;
    logic       p_load, p_hold, p_to_o, o_hold;
    logic [4:0] rd_a, rd_b;
    logic       hit_rd_a, hit_rd_b;
    logic       hit_p_rs, hit_p_rt;
    logic       hit_o_rs, hit_o_rt;

    assign adv_o  = !o_valid_q || bus.out_ready;
    assign adv_p  = !p_valid_q || adv_o;
    assign p_load = adv_p && bus.in_valid;
    assign p_hold = p_valid_q && !adv_o;
    assign p_to_o = p_valid_q && adv_o;
    assign o_hold = o_valid_q && !bus.out_ready;

    // A stalled P re-reads its own registers every cycle, so the read data
    // seen at the P->O edge always reflects the previous edge's contents.
    assign rd_a = p_hold ? p_q.rs : bus.in_rs;
    assign rd_b = p_hold ? p_q.rt : bus.in_rt;

    assign hit_rd_a = bus.wb_en && (bus.wb_addr == rd_a);
    assign hit_rd_b = bus.wb_en && (bus.wb_addr == rd_b);
    assign hit_p_rs = bus.wb_en && (bus.wb_addr == p_q.rs);
    assign hit_p_rt = bus.wb_en && (bus.wb_addr == p_q.rt);
    assign hit_o_rs = bus.wb_en && (bus.wb_addr == o_q.rs);
    assign hit_o_rt = bus.wb_en && (bus.wb_addr == o_q.rt);

    always_comb begin
        p_valid_d = p_valid_q;
        o_valid_d = o_valid_q;
        p_d       = p_q;
        o_d       = o_q;

        // The read sampled on this edge returns pre-write contents, so a
        // write to the address being read is captured here instead.
        if (p_load || p_hold) begin
            p_d.fwd_a = hit_rd_a;
            p_d.fwd_b = hit_rd_b;
            if (hit_rd_a) p_d.fwd_data_a = bus.wb_data;
            if (hit_rd_b) p_d.fwd_data_b = bus.wb_data;
        end

        if (adv_p) begin
            p_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                p_d.op  = bus.in_op;
                p_d.rs  = bus.in_rs;
                p_d.rt  = bus.in_rt;
                p_d.rd  = bus.in_rd;
                p_d.imm = bus.in_imm;
            end
        end

        if (adv_o) o_valid_d = p_valid_q;

        if (p_to_o) begin
            o_d.op  = p_q.op;
            o_d.rs  = p_q.rs;
            o_d.rt  = p_q.rt;
            o_d.rd  = p_q.rd;
            o_d.imm = p_q.imm;
            o_d.a   = hit_p_rs ? bus.wb_data : (p_q.fwd_a ? p_q.fwd_data_a : bus.rf_dataa);
            o_d.b   = hit_p_rt ? bus.wb_data : (p_q.fwd_b ? p_q.fwd_data_b : bus.rf_datab);
        end else if (o_hold) begin
            if (hit_o_rs) o_d.a = bus.wb_data;
            if (hit_o_rt) o_d.b = bus.wb_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_valid_q <= 1'b0;
            o_valid_q <= 1'b0;
            p_q       <= '0;
            o_q       <= '0;
        end else begin
            p_valid_q <= p_valid_d;
            o_valid_q <= o_valid_d;
            p_q       <= p_d;
            o_q       <= o_d;
        end
    end

    assign bus.in_ready  = adv_p;
    assign bus.rf_addra  = rd_a;
    assign bus.rf_addrb  = rd_b;
    assign bus.out_valid = o_valid_q;
    assign bus.out_op    = o_q.op;
    assign bus.out_rd    = o_q.rd;
    assign bus.out_imm   = o_q.imm;
    assign bus.out_a     = o_q.a;
    assign bus.out_b     = o_q.b;

endmodule
